// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//
// Result/status stage behind a 6502-style ALU. Captures the ALU result into
// an adder hold register, maintains the processor status register
// {N,V,1,1,D,I,Z,C}, and (optionally) applies the two-step BCD correction
// used by ADC/SBC when the D flag is set.
//
// Build option:
//   ALU_DECIMAL_EN  defined   -> DAA/DSA requests run the DEC_LO/DEC_HI
//                                correction sequence (3-edge latency).
//                   undefined -> every load is binary, sig_DAA/sig_DSA/sig_HC
//                                are ignored and sig_BUSY stays 0. D remains a
//                                plain settable/clearable flag.
//
// Ports:
//   sig_CLK, sig_RST       clock, synchronous active-high reset
//   ALU_OUT, sig_ACR,
//   sig_AVR, sig_HC        ALU result, carry, overflow, half carry
//   sig_ALU_LOAD           capture the ALU result this cycle (ignored if busy)
//   sig_DAA, sig_DSA       decimal add / subtract correction request
//   sig_UPD_NZ/_C/_V       per-flag write enables for the load
//   sig_P_LOAD, P_IN       load status from the data bus (highest priority)
//   sig_SET_x / sig_CLR_x  single-flag commands for C, I, D; clear for V
//   ADD_OUT                adder hold register
//   P_OUT                  status register, bits 5:4 always read 1
//   sig_BUSY               decimal correction in progress
//   sig_VALID              one-cycle pulse: ADD_OUT/P_OUT are final
// ---------------------------------------------------------------------------
module alu_result_stage (
    input  logic       sig_CLK,
    input  logic       sig_RST,
    input  logic [7:0] ALU_OUT,
    input  logic       sig_ACR,
    input  logic       sig_AVR,
    input  logic       sig_HC,
    input  logic       sig_ALU_LOAD,
    input  logic       sig_DAA,
    input  logic       sig_DSA,
    input  logic       sig_UPD_NZ,
    input  logic       sig_UPD_C,
    input  logic       sig_UPD_V,
    input  logic       sig_P_LOAD,
    input  logic [7:0] P_IN,
    input  logic       sig_SET_C,
    input  logic       sig_CLR_C,
    input  logic       sig_SET_I,
    input  logic       sig_CLR_I,
    input  logic       sig_SET_D,
    input  logic       sig_CLR_D,
    input  logic       sig_CLR_V,
    output logic [7:0] ADD_OUT,
    output logic [7:0] P_OUT,
    output logic       sig_BUSY,
    output logic       sig_VALID
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DEC_LO = 2'd1,
        DEC_HI = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] add_reg, add_next;
    logic       n_reg, n_next;
    logic       v_reg, v_next;
    logic       d_reg, d_next;
    logic       i_reg, i_next;
    logic       z_reg, z_next;
    logic       c_reg, c_next;
    logic       busy_reg, busy_next;
    logic       valid_reg, valid_next;

    // P_IN[5:4] has no storage behind it: those status bits are constant.
    logic unused_p_in;
    assign unused_p_in = ^P_IN[5:4];

    // Single-flag commands for C (bit 0), I (bit 1), D (bit 2). A command
    // only acts when exactly one of set/clear is asserted.
    logic [2:0] cmd_set, cmd_clr, cmd_hit;
    assign cmd_set = {sig_SET_D, sig_SET_I, sig_SET_C};
    assign cmd_clr = {sig_CLR_D, sig_CLR_I, sig_CLR_C};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cmd
            assign cmd_hit[gi] = cmd_set[gi] ^ cmd_clr[gi];
        end
    endgenerate

`ifdef ALU_DECIMAL_EN
    // Operands latched at the load edge for the correction sequence.
    logic hc_reg, hc_next;
    logic acr_reg, acr_next;
    logic sub_reg, sub_next;
    logic upd_c_reg, upd_c_next;
    logic dec_req, lo_adj, hi_adj;

    // DAA together with DSA is meaningless and falls back to a binary load.
    assign dec_req = (sig_DAA ^ sig_DSA) & d_reg;

    // Add corrects a nibble on carry-out or a non-BCD digit; subtract
    // corrects only when the nibble borrowed (carry clear).
    assign lo_adj = sub_reg ? ~hc_reg  : (hc_reg  | (add_reg[3:0] > 4'd9));
    assign hi_adj = sub_reg ? ~acr_reg : (acr_reg | (add_reg[7:4] > 4'd9));
`else
    logic unused_dec;
    assign unused_dec = sig_DAA ^ sig_DSA ^ sig_HC;
`endif

    always_comb begin
        state_next = state_reg;
        add_next   = add_reg;
        n_next     = n_reg;
        v_next     = v_reg;
        d_next     = d_reg;
        i_next     = i_reg;
        z_next     = z_reg;
        c_next     = c_reg;
        busy_next  = 1'b0;
        valid_next = 1'b0;
`ifdef ALU_DECIMAL_EN
        hc_next    = hc_reg;
        acr_next   = acr_reg;
        sub_next   = sub_reg;
        upd_c_next = upd_c_reg;
`endif

        // Lowest priority: ALU load and decimal correction.
        case (state_reg)
            IDLE: begin
                if (sig_ALU_LOAD) begin
                    add_next = ALU_OUT;
                    if (sig_UPD_NZ) begin
                        n_next = ALU_OUT[7];
                        z_next = (ALU_OUT == 8'h00);
                    end
                    if (sig_UPD_V) begin
                        v_next = sig_AVR;
                    end
`ifdef ALU_DECIMAL_EN
                    hc_next    = sig_HC;
                    acr_next   = sig_ACR;
                    sub_next   = sig_DSA;
                    upd_c_next = sig_UPD_C;
                    if (dec_req) begin
                        // N/Z/V keep the binary result; C waits for DEC_HI.
                        state_next = DEC_LO;
                        busy_next  = 1'b1;
                    end else begin
                        if (sig_UPD_C) begin
                            c_next = sig_ACR;
                        end
                        valid_next = 1'b1;
                    end
`else
                    if (sig_UPD_C) begin
                        c_next = sig_ACR;
                    end
                    valid_next = 1'b1;
`endif
                end
            end
`ifdef ALU_DECIMAL_EN
            DEC_LO: begin
                if (lo_adj) begin
                    add_next = sub_reg ? (add_reg - 8'h06) : (add_reg + 8'h06);
                end
                state_next = DEC_HI;
                busy_next  = 1'b1;
            end
            DEC_HI: begin
                if (hi_adj) begin
                    add_next = sub_reg ? (add_reg - 8'h60) : (add_reg + 8'h60);
                end
                // For add, the high-digit adjust is exactly the decimal carry.
                if (upd_c_reg) begin
                    c_next = sub_reg ? acr_reg : hi_adj;
                end
                state_next = IDLE;
                valid_next = 1'b1;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase

        // Single-flag commands override the ALU/decimal flag update.
        if (cmd_hit[0]) begin
            c_next = cmd_set[0];
        end
        if (cmd_hit[1]) begin
            i_next = cmd_set[1];
        end
        if (cmd_hit[2]) begin
            d_next = cmd_set[2];
        end
        if (sig_CLR_V) begin
            v_next = 1'b0;
        end

        // Bus load of P overrides every other flag source.
        if (sig_P_LOAD) begin
            n_next = P_IN[7];
            v_next = P_IN[6];
            d_next = P_IN[3];
            i_next = P_IN[2];
            z_next = P_IN[1];
            c_next = P_IN[0];
        end
    end

    always_ff @(posedge sig_CLK) begin
        if (sig_RST) begin
            state_reg <= IDLE;
            add_reg   <= 8'h00;
            n_reg     <= 1'b0;
            v_reg     <= 1'b0;
            d_reg     <= 1'b0;
            i_reg     <= 1'b1;
            z_reg     <= 1'b0;
            c_reg     <= 1'b0;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
`ifdef ALU_DECIMAL_EN
            hc_reg    <= 1'b0;
            acr_reg   <= 1'b0;
            sub_reg   <= 1'b0;
            upd_c_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            add_reg   <= add_next;
            n_reg     <= n_next;
            v_reg     <= v_next;
            d_reg     <= d_next;
            i_reg     <= i_next;
            z_reg     <= z_next;
            c_reg     <= c_next;
            busy_reg  <= busy_next;
            valid_reg <= valid_next;
`ifdef ALU_DECIMAL_EN
            hc_reg    <= hc_next;
            acr_reg   <= acr_next;
            sub_reg   <= sub_next;
            upd_c_reg <= upd_c_next;
`endif
        end
    end

    assign ADD_OUT   = add_reg;
    assign P_OUT     = {n_reg, v_reg, 2'b11, d_reg, i_reg, z_reg, c_reg};
    assign sig_BUSY  = busy_reg;
    assign sig_VALID = valid_reg;

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Ports SHALL be as follows (clock and reset first):
- sig_CLK  in  1  clock; all state changes on its rising edge.
- sig_RST  in  1  synchronous active-high reset.
- ALU_OUT  in  8  ALU result.
- sig_ACR  in  1  ALU carry.
- sig_AVR  in  1  ALU overflow.
- sig_HC  in  1  ALU half carry.
- sig_ALU_LOAD  in  1  capture this cycle's ALU result.
- sig_DAA  in  1  decimal-add correction request, sampled with sig_ALU_LOAD.
- sig_DSA  in  1  decimal-subtract correction request, sampled with sig_ALU_LOAD.
- sig_UPD_NZ  in  1  write N/Z on this load.
- sig_UPD_C  in  1  write C on this load.
- sig_UPD_V  in  1  write V on this load.
- sig_P_LOAD  in  1  load P from P_IN (PLP/RTI).
- P_IN  in  8  status value from data bus.
- sig_SET_C, sig_CLR_C, sig_SET_I, sig_CLR_I, sig_SET_D, sig_CLR_D, sig_CLR_V  in  1 each  single-flag commands.
- ADD_OUT  out  8  adder hold register.
- P_OUT  out  8  status register {N,V,1,1,D,I,Z,C}.
- sig_BUSY  out  1  decimal correction in progress.
- sig_VALID  out  1  one-cycle pulse: ADD_OUT/P_OUT final.

Function
REQ-003 The FSM SHALL have states IDLE, DEC_LO, DEC_HI; all outputs SHALL be registered.
REQ-004 In IDLE, sig_ALU_LOAD SHALL latch ALU_OUT into ADD and write the enabled flags: N=ALU_OUT[7], Z=(ALU_OUT==0), C=sig_ACR, V=sig_AVR; it SHALL also latch sig_HC and sig_ACR internally.
REQ-005 In a binary load (sig_DAA=sig_DSA=0), the FSM SHALL stay in IDLE and sig_VALID SHALL be high for exactly the cycle after the load edge.
REQ-006 In a decimal load (sig_DAA or sig_DSA, with P.D=1), the FSM SHALL go to DEC_LO, and sig_BUSY SHALL be high from the next cycle until the final edge.
REQ-007 Decimal add: DEC_LO SHALL perform ADD+=06h (8-bit) if HC=1 or ADD[3:0]>9. DEC_HI SHALL then perform ADD+=60h and C=1 if latched carry=1 or ADD[7:4]>9; otherwise C=latched carry.
REQ-008 Decimal subtract: DEC_LO SHALL perform ADD-=06h if HC=0. DEC_HI SHALL perform ADD-=60h if latched carry=0. C SHALL be the latched carry.
REQ-009 On a decimal load, N, Z and V SHALL come from the binary result (NMOS behaviour). C SHALL be written only at the DEC_HI edge, and only if sig_UPD_C was set.
REQ-010 The DEC_HI edge SHALL return the FSM to IDLE, and sig_VALID SHALL pulse in the following cycle; decimal latency SHALL be 3 edges.
REQ-011 If sig_DAA and sig_DSA are both high, the load SHALL be treated as binary.
REQ-012 sig_ALU_LOAD while sig_BUSY=1 SHALL be ignored.
REQ-013 A single-flag command SHALL set or clear its flag on the edge; if set and clear are both asserted for the same flag, that flag SHALL be unchanged.
REQ-014 sig_P_LOAD SHALL load P_IN[7:6,3:0] and SHALL override any simultaneous flag write from a load, a command, or DEC_HI.
REQ-015 Flag write priority SHALL be P_LOAD > single-flag command > ALU/decimal update.
REQ-016 P_OUT[5:4] SHALL always read 1.

Reset
REQ-017 On a sig_RST edge, the block SHALL set ADD_OUT=00h, P_OUT=34h (I=1), FSM=IDLE, sig_BUSY=0 and sig_VALID=0.
REQ-018 Reset SHALL override all other inputs in the same cycle and SHALL abort any decimal correction without a sig_VALID pulse.

Configuration
REQ-019 When macro ALU_DECIMAL_EN is defined, decimal correction SHALL be implemented per REQ-006..REQ-011.
REQ-020 When ALU_DECIMAL_EN is undefined, sig_DAA, sig_DSA and sig_HC SHALL be ignored, every load SHALL be binary, sig_BUSY SHALL be tied 0, and the D flag SHALL remain settable/clearable with no arithmetic effect.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset: sig_RST=1 for one edge -> P_OUT=34h, ADD_OUT=00h, sig_BUSY=0, sig_VALID=0.
- Binary: ALU_OUT=80h, ACR=1, AVR=1, all UPD set -> next cycle ADD_OUT=80h, P_OUT=F5h, sig_VALID high for exactly 1 cycle.
- Decimal add (D=1): ALU_OUT=9Eh, HC=0, ACR=0, sig_DAA (58+46) -> after 3 edges ADD_OUT=04h, C=1, sig_BUSY high for 2 cycles, then sig_VALID pulse.
- Decimal subtract (D=1): ALU_OUT=2Dh, HC=0, ACR=1, sig_DSA (42-15) -> ADD_OUT=27h, C=1.
- Priority: P_LOAD with P_IN=00h plus sig_SET_C in the same cycle -> P_OUT=30h. Set/clear: sig_SET_I and sig_CLR_I together -> I unchanged.
- Abort and ignore: sig_RST during DEC_LO -> P_OUT=34h with no sig_VALID pulse. sig_ALU_LOAD during BUSY -> ADD_OUT unaffected.
